// File: rtl/mfp_mac_arbiter.sv
// Round-robin arbiter in front of one shared signed multiply-accumulate datapath.
// Each granted job streams operand beats; the reduced dot product is returned with the owner id.
module mfp_mac_arbiter #(
  parameter int NREQ     = 4,
  parameter int In1W     = 8,
  parameter int In2W     = 8,
  parameter int AccW     = 20,
  parameter int OutW     = 16,
  parameter int isFloor  = 1,
  parameter int Saturate = 0,
  localparam int IdW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [In1W*NREQ-1:0]   req_in1,
  input  logic [In2W*NREQ-1:0]   req_in2,
  output logic [NREQ-1:0]        req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [OutW-1:0]        res_data,
  output logic [IdW-1:0]         res_id
);

  localparam int PW = In1W + In2W - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  // Symmetric clamp range: the most negative code is never produced.
  localparam logic signed [AccW:0] ACC_MAX = {2'b00, {(AccW-1){1'b1}}};
  localparam logic signed [AccW:0] ACC_MIN = {2'b11, {(AccW-2){1'b0}}, 1'b1};

  logic [1:0]             state;
  logic [IdW-1:0]         ptr;
  logic [IdW-1:0]         g;
  logic [IdW-1:0]         g_arb;
  logic                   arb_hit;
  logic [IdW:0]           scan;
  logic signed [In1W-1:0] op1;
  logic signed [In2W-1:0] op2;
  logic signed [PW-1:0]   prod;
  logic                   accept;
  logic signed [PW-1:0]   prod_p0;
  logic                   vld_p0;
  logic signed [AccW-1:0] acc_p1;
  logic signed [OutW-1:0] res_full;

  function automatic logic signed [AccW-1:0] acc_add(input logic signed [AccW-1:0] a,
                                                     input logic signed [PW-1:0]   p);
    logic signed [AccW:0] s;
    s = {a[AccW-1], a} + {{(AccW+1-PW){p[PW-1]}}, p};
    if (Saturate != 0 && s > ACC_MAX) return ACC_MAX[AccW-1:0];
    if (Saturate != 0 && s < ACC_MIN) return ACC_MIN[AccW-1:0];
    return s[AccW-1:0];
  endfunction

  function automatic logic signed [OutW-1:0] round_out(input logic signed [OutW-1:0] f,
                                                       input logic                   rb);
    logic signed [OutW:0] s;
    s = {f[OutW-1], f} + {{OutW{1'b0}}, rb};
    // Adding a non-negative round bit can only overflow upward.
    if (Saturate != 0 && s[OutW] != s[OutW-1]) return {1'b0, {(OutW-1){1'b1}}};
    return s[OutW-1:0];
  endfunction

  always_comb begin
    g_arb   = ptr;
    arb_hit = 1'b0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + (IdW+1)'(k);
      if (scan >= (IdW+1)'(NREQ)) scan = scan - (IdW+1)'(NREQ);
      if (!arb_hit && req_valid[scan[IdW-1:0]]) begin
        arb_hit = 1'b1;
        g_arb   = scan[IdW-1:0];
      end
    end
  end

  always_comb begin
    op1       = '0;
    op2       = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g == IdW'(i)) begin
        op1          = req_in1[i*In1W +: In1W];
        op2          = req_in2[i*In2W +: In2W];
        req_ready[i] = en && (state == BUSY);
      end
    end
  end

  assign accept = (state == BUSY) && en && req_valid[g];
  assign prod   = {{(PW-In1W){op1[In1W-1]}}, op1} * {{(PW-In2W){op2[In2W-1]}}, op2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      g       <= '0;
      prod_p0 <= '0;
      vld_p0  <= 1'b0;
      acc_p1  <= '0;
    end else if (en) begin
      // p0: product of the accepted beat
      vld_p0 <= accept;
      if (accept) prod_p0 <= prod;
      // p1: accumulate
      if (vld_p0) acc_p1 <= acc_add(acc_p1, prod_p0);
      case (state)
        IDLE: if (arb_hit) begin
          state   <= BUSY;
          g       <= g_arb;
          acc_p1  <= '0;
          prod_p0 <= '0;
        end
        BUSY:  if (accept && req_last[g]) state <= DRAIN;
        DRAIN: state <= OUT;
        OUT: if (res_ready) begin
          state <= IDLE;
          ptr   <= (g == IdW'(NREQ-1)) ? '0 : g + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (OutW == AccW) begin : g_full
      assign res_full = acc_p1;
    end else if (isFloor != 0) begin : g_floor
      logic acc_lsb_unused;
      assign acc_lsb_unused = ^acc_p1[AccW-OutW-1:0];
      assign res_full = acc_p1[AccW-1 -: OutW];
    end else begin : g_round
      logic acc_lsb_unused;
      assign acc_lsb_unused = ^acc_p1[AccW-OutW-1:0];
      assign res_full = round_out(acc_p1[AccW-1 -: OutW], acc_p1[AccW-OutW-1]);
    end
  endgenerate

  assign res_valid = (state == OUT);
  assign res_data  = res_valid ? res_full : '0;
  assign res_id    = g;

endmodule

// File: tb/tb_mfp_mac_arbiter.sv
// Bench for mfp_mac_arbiter: three parameterisations (floor/wrap, round/wrap, floor/saturate)
// share one stimulus stream; results are checked against a queue of expected records.
module tb_mfp_mac_arbiter;

  localparam int NREQ = 4;
  localparam int In1W = 8;
  localparam int In2W = 8;
  localparam int OutW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [In1W*NREQ-1:0] req_in1;
  logic [In2W*NREQ-1:0] req_in2;
  logic                 res_ready;

  logic [NREQ-1:0] rdy0, rdy1, rdy2;
  logic            rv0, rv1, rv2;
  logic [OutW-1:0] rd0, rd1, rd2;
  logic [1:0]      rid0, rid1, rid2;

  always #5 clk = ~clk;

  mfp_mac_arbiter #(.isFloor(1), .Saturate(0)) u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_last(req_last),
    .req_in1(req_in1), .req_in2(req_in2), .req_ready(rdy0), .res_valid(rv0),
    .res_ready(res_ready), .res_data(rd0), .res_id(rid0));

  mfp_mac_arbiter #(.isFloor(0), .Saturate(0)) u_rnd (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_last(req_last),
    .req_in1(req_in1), .req_in2(req_in2), .req_ready(rdy1), .res_valid(rv1),
    .res_ready(res_ready), .res_data(rd1), .res_id(rid1));

  mfp_mac_arbiter #(.isFloor(1), .Saturate(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_last(req_last),
    .req_in1(req_in1), .req_in2(req_in2), .req_ready(rdy2), .res_valid(rv2),
    .res_ready(res_ready), .res_data(rd2), .res_id(rid2));

  typedef struct {
    int id; int nb; int a; int b;
    int e_def; int e_rnd; int e_sat;
  } vec_t;

  typedef struct {
    int id; int e_def; int e_rnd; int e_sat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   popped = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input int id, input int ed, input int er, input int es);
    exp_t e;
    e.id = id; e.e_def = ed; e.e_rnd = er; e.e_sat = es;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && en && res_ready && (rv0 || rv1 || rv2)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id %0d data %0d, expected no result",
                 rid0, $signed(rd0));
      end else begin
        e = sb.pop_front();
        check("res_valid_def", int'(rv0), 1);
        check("res_valid_rnd", int'(rv1), 1);
        check("res_valid_sat", int'(rv2), 1);
        check("res_id", int'(rid0), e.id);
        check("data_floor_wrap", int'($signed(rd0)), e.e_def);
        check("data_round_wrap", int'($signed(rd1)), e.e_rnd);
        check("data_floor_sat", int'($signed(rd2)), e.e_sat);
        popped++;
      end
    end
  end

  task automatic wait_ready(input int id);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy0[id] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: requester %0d got no ready, expected ready within 200 cycles", id);
    end
  endtask

  task automatic drive_job(input int id, input int nb, input int a, input int b,
                           input bit check_lat, input bit en_gap);
    int lat;
    for (int k = 0; k < nb; k++) begin
      req_valid[id] = 1'b1;
      req_last[id]  = (k == nb - 1);
      req_in1[id*In1W +: In1W] = In1W'(a);
      req_in2[id*In2W +: In2W] = In2W'(b);
      if (en_gap) begin
        en = 1'b0;
        @(negedge clk);
        check("ready_while_en0", int'(rdy0), 0);
        @(posedge clk); #1;
        en = 1'b1;
      end
      wait_ready(id);
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
    if (check_lat) begin
      lat = 1;
      while (!rv0 && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      check("latency", lat, 2);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   t;
    int   target;

    vecs[0] = '{1,  4,  100,  100,   2500,   2500,   2500};
    vecs[1] = '{0,  1,    3,    8,      1,      2,      1};
    vecs[2] = '{2,  1,   -5,    7,     -3,     -2,     -3};
    vecs[3] = '{3, 40,  127,  127, -25214, -25213,  32767};
    vecs[4] = '{1,  2, -128,  127,  -2032,  -2032,  -2032};
    vecs[5] = '{0,  3,   -1,    1,     -1,      0,     -1};
    vecs[6] = '{2,  5,   50,  -60,   -938,   -937,   -938};
    vecs[7] = '{3, 40, -128,  127,  24896,  24896, -32768};

    req_valid = '0;
    req_last  = '0;
    req_in1   = '0;
    req_in2   = '0;
    res_ready = 1'b1;
    rst_n     = 1'b0;
    en        = 1'b0;

    // Reset must load even with the clock enable low.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_req_ready", int'(rdy0), 0);
    check("reset_res_valid", int'(rv0), 0);
    check("reset_res_data", int'(rd0), 0);
    check("reset_res_id", int'(rid0), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    en    = 1'b1;

    // All requesters hold single-beat jobs: service order follows the rotating pointer.
    for (int i = 0; i < NREQ; i++) begin
      req_in1[i*In1W +: In1W] = In1W'(i + 1);
      req_in2[i*In2W +: In2W] = In2W'(16);
    end
    push_exp(0, 1, 1, 1);
    push_exp(1, 2, 2, 2);
    push_exp(2, 3, 3, 3);
    push_exp(3, 4, 4, 4);
    push_exp(0, 1, 1, 1);
    target    = popped + 5;
    req_last  = '1;
    req_valid = '1;
    t = 0;
    while (popped < target && t < 300) begin
      @(negedge clk); #1;
      if (sb.size() > 0 && rdy0 != '0) check("ready_owner", int'(rdy0), 1 << sb[0].id);
      t++;
    end
    req_valid = '0;
    req_last  = '0;
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL rr_timeout: %0d results served, expected %0d", popped, target);
    end
    wait_drain();

    for (int v = 0; v < 8; v++) begin
      push_exp(vecs[v].id, vecs[v].e_def, vecs[v].e_rnd, vecs[v].e_sat);
      drive_job(vecs[v].id, vecs[v].nb, vecs[v].a, vecs[v].b, 1'b1, 1'b0);
    end
    wait_drain();

    // Enable toggled between beats and downstream stalled: held result must not move.
    res_ready = 1'b0;
    push_exp(1, 2500, 2500, 2500);
    drive_job(1, 4, 100, 100, 1'b0, 1'b1);
    t = 0;
    while (!rv0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", int'(rv0), 1);
      check("stall_data", int'($signed(rd0)), 2500);
      check("stall_id", int'(rid0), 1);
      @(posedge clk); #1;
      en = (c != 2);
    end
    en        = 1'b1;
    res_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a job: the partial job must vanish.
    req_in1[0 +: In1W] = In1W'(50);
    req_in2[0 +: In2W] = In2W'(50);
    req_last[0]  = 1'b0;
    req_valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    wait_ready(0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_res_valid", int'(rv0), 0);
    check("midreset_req_ready", int'(rdy0), 0);
    repeat (3) @(posedge clk);
    #1;
    check("midreset_no_result", int'(rv0), 0);
    push_exp(2, -3, -2, -3);
    drive_job(2, 1, -5, 7, 1'b1, 1'b0);
    wait_drain();
    check("queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
